// File: rtl/dll_rx_demux_if.sv
// Signal bundle of the receive-side DLL demultiplexer: PIPE beats in,
// TLP ready/valid stream out, DLLP pulse out, error pulse out.
interface dll_rx_demux_if #(
    parameter int PIPE_DATA_WIDTH = 256
);
    localparam int LW = PIPE_DATA_WIDTH / 8;

    logic [1:0]         DLCMSM_i;
    logic [7:0][LW-1:0] data_PIPE_i;
    logic               data_PIPE_valid_i;
    logic               data_PIPE_sop_i;
    logic               data_PIPE_eop_i;
    logic               data_PIPE_dllp_i;
    logic [7:0][LW-1:0] data_TLP_o;
    logic               TLP_valid_o;
    logic               TLP_ready_i;
    logic               TLP_last_o;
    logic               TLP_err_o;
    logic [7:0][LW-1:0] data_DLLP_o;
    logic               DLLP_valid_o;
    logic               rx_err_o;

    modport master (
        output DLCMSM_i, data_PIPE_i, data_PIPE_valid_i, data_PIPE_sop_i,
               data_PIPE_eop_i, data_PIPE_dllp_i, TLP_ready_i,
        input  data_TLP_o, TLP_valid_o, TLP_last_o, TLP_err_o,
               data_DLLP_o, DLLP_valid_o, rx_err_o
    );

    modport slave (
        input  DLCMSM_i, data_PIPE_i, data_PIPE_valid_i, data_PIPE_sop_i,
               data_PIPE_eop_i, data_PIPE_dllp_i, TLP_ready_i,
        output data_TLP_o, TLP_valid_o, TLP_last_o, TLP_err_o,
               data_DLLP_o, DLLP_valid_o, rx_err_o
    );
endinterface

// File: rtl/dll_rx_demux.sv
// RX DLL demux: TLP/DLLP split, DLCMSM gating, FWFT TLP FIFO with admission control.
// Optional DLL_RX_STATS_EN adds saturating TLP/DLLP/drop counters.
module dll_rx_demux #(
    parameter int PIPE_DATA_WIDTH = 256,
    parameter int FIFO_DEPTH      = 16,
    parameter int MAX_TLP_BEATS   = 8
) (
    input  logic          sclk,
    input  logic          srst,
    dll_rx_demux_if.slave bus
`ifdef DLL_RX_STATS_EN
   ,output logic [15:0]   stat_tlp_o,
    output logic [15:0]   stat_dllp_o,
    output logic [15:0]   stat_drop_o
`endif
);
    localparam int LW = PIPE_DATA_WIDTH / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MAX_TLP_BEATS + 1);

    typedef logic [7:0][LW-1:0] beat_t;
    typedef struct packed {
        beat_t data;
        logic  last;
        logic  err;
    } entry_t;
    typedef enum logic [1:0] { IDLE, TLP_RUN, DROP } state_t;

    state_t        state;
    logic [CW-1:0] beat_cnt;
    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ, free;
    entry_t        head, wr_entry;
    logic          wr_en, rd_en, tlp_valid;

    logic active, eop, sop_v, body_v, dllp_sop, tlp_sop, in_run;
    logic admit, run_abort, body_wr, trunc, dllp_take, err_evt;

    assign active    = bus.DLCMSM_i == 2'b11;
    assign eop       = bus.data_PIPE_eop_i;
    assign sop_v     = bus.data_PIPE_valid_i & bus.data_PIPE_sop_i;
    assign body_v    = bus.data_PIPE_valid_i & ~bus.data_PIPE_sop_i;
    assign dllp_sop  = sop_v & bus.data_PIPE_dllp_i;
    assign tlp_sop   = sop_v & ~bus.data_PIPE_dllp_i;
    assign in_run    = state == TLP_RUN;
    assign free      = (AW+1)'(FIFO_DEPTH) - occ;

    // One entry beyond a max-size TLP is reserved so an abort marker always fits.
    assign admit     = tlp_sop & ~in_run & active &
                       (free >= (AW+1)'(MAX_TLP_BEATS + 1));
    assign run_abort = in_run & (sop_v | ~active);
    assign body_wr   = in_run & active & body_v;
    assign trunc     = body_wr & ~eop & (beat_cnt == CW'(MAX_TLP_BEATS - 1));
    assign dllp_take = dllp_sop & eop & (bus.DLCMSM_i != 2'b00);
    assign err_evt   = ((state == IDLE) & body_v) | (dllp_sop & ~eop) |
                       (tlp_sop & active & ~admit) | run_abort | trunc;

    assign wr_en = admit | body_wr | run_abort;

    always_comb begin
        wr_entry.data = bus.data_PIPE_i;
        wr_entry.last = eop | trunc;
        wr_entry.err  = trunc;
        if (run_abort) begin
            wr_entry.data = '0;
            wr_entry.last = 1'b1;
            wr_entry.err  = 1'b1;
        end
    end

    // FWFT FIFO: head is read combinationally, outputs are zero while empty.
    assign rd_en     = tlp_valid & bus.TLP_ready_i;
    assign tlp_valid = occ != '0;
    assign head      = mem[rd_ptr];

    assign bus.TLP_valid_o = tlp_valid;
    assign bus.data_TLP_o  = tlp_valid ? head.data : '0;
    assign bus.TLP_last_o  = tlp_valid & head.last;
    assign bus.TLP_err_o   = tlp_valid & head.err;

    always_ff @(posedge sclk) begin
        if (wr_en) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge sclk) disable iff (srst)
        !(wr_en && occ == (AW+1)'(FIFO_DEPTH)));

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            state            <= IDLE;
            beat_cnt         <= '0;
            bus.DLLP_valid_o <= 1'b0;
            bus.data_DLLP_o  <= '0;
            bus.rx_err_o     <= 1'b0;
        end else begin
            bus.rx_err_o     <= err_evt;
            bus.DLLP_valid_o <= dllp_take;
            if (dllp_take) bus.data_DLLP_o <= bus.data_PIPE_i;
            case (state)
                TLP_RUN: begin
                    if (run_abort) begin
                        // Remaining beats of an aborted packet are swallowed in DROP.
                        beat_cnt <= '0;
                        state    <= (bus.data_PIPE_valid_i & eop) ? IDLE : DROP;
                    end else if (body_v) begin
                        if (eop) begin
                            state    <= IDLE;
                            beat_cnt <= '0;
                        end else if (trunc) begin
                            state    <= DROP;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (sop_v) begin
                        if (admit && !eop) begin
                            state    <= TLP_RUN;
                            beat_cnt <= CW'(1);
                        end else begin
                            state <= eop ? IDLE : DROP;
                        end
                    end else if (body_v && eop) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef DLL_RX_STATS_EN
    logic       tlp_ok, drop_pkt;
    logic [1:0] drop_inc;

    function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, c} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign tlp_ok   = wr_en & wr_entry.last & ~wr_entry.err;
    assign drop_pkt = (dllp_sop & ~dllp_take) | (tlp_sop & ~admit);
    assign drop_inc = {1'b0, drop_pkt} + {1'b0, run_abort | trunc};

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            stat_tlp_o  <= '0;
            stat_dllp_o <= '0;
            stat_drop_o <= '0;
        end else begin
            stat_tlp_o  <= sat_add(stat_tlp_o, {1'b0, tlp_ok});
            stat_dllp_o <= sat_add(stat_dllp_o, {1'b0, dllp_take});
            stat_drop_o <= sat_add(stat_drop_o, drop_inc);
        end
    end
`endif

endmodule
